// File: rtl/led_pattern_ctrl_pkg.sv
// Shared definitions for the multi-channel LED pattern controller.
// Holds the channel mode encoding, used by the block and its bench.
package led_pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/period/count registers plus registered led and busy.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   tick_i       shared prescaler strobe
//   we_i         decoded write enable for this channel
//   cfg_mode_i   mode to load on write
//   cfg_period_i period to load on write
//   led_o        LED drive, 1 = lit
//   busy_o       1 while a ONESHOT pulse is in progress
module led_channel
  import led_pattern_ctrl_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter int          RST_PERIOD = 499,
  parameter logic [1:0]  RST_MODE   = 2'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  output logic             led_o,
  output logic             busy_o
);

  led_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= led_mode_e'(RST_MODE);
      period_q <= CNT_W'(RST_PERIOD);
      count_q  <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    count_d  = count_q;
    led_d    = led_q;
    busy_d   = busy_q;
    if (we_i) begin
      // A write takes priority over a coincident tick and restarts the pattern lit.
      mode_d   = led_mode_e'(cfg_mode_i);
      period_d = cfg_period_i;
      count_d  = '0;
      led_d    = (cfg_mode_i != MODE_OFF);
      busy_d   = (cfg_mode_i == MODE_ONESHOT);
    end else begin
      unique case (mode_q)
        MODE_OFF: begin
          led_d   = 1'b0;
          busy_d  = 1'b0;
          count_d = '0;
        end
        MODE_ON: begin
          led_d   = 1'b1;
          busy_d  = 1'b0;
          count_d = '0;
        end
        MODE_BLINK: begin
          busy_d = 1'b0;
          if (tick_i) begin
            if (count_q == period_q) begin
              led_d   = ~led_q;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        MODE_ONESHOT: begin
          if (tick_i) begin
            if (count_q == period_q) begin
              // Pulse expired: park the channel in OFF.
              led_d   = 1'b0;
              busy_d  = 1'b0;
              mode_d  = MODE_OFF;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern controller: shared prescaler plus per-channel
// OFF/ON/BLINK/ONESHOT engines configured through a one-cycle write strobe.
// Ports:
//   clk, rst_n   10 kHz LFOSC clock, async active-low reset
//   cfg_we       config write strobe
//   cfg_ch       target channel; indices >= NUM_CH are ignored
//   cfg_mode     0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
//   cfg_period   period P; toggle/hold every P+1 ticks
//   led          per-channel LED drive
//   busy         per-channel ONESHOT-in-progress
//   tick         prescaler strobe, one clk every PRESCALE clks
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         CNT_W      = 16,
  parameter int         PRESCALE   = 10,
  parameter int         RST_PERIOD = 499,
  parameter logic [1:0] RST_MODE   = 2'd2,
  localparam int        CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic              tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;

  // tick is registered: it is set on the edge that loads PS_LAST so it is high
  // exactly while the prescaler holds PS_LAST (constantly high for PRESCALE=1).
  always_comb begin
    ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    tick_d = (ps_d == PS_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Equality decode: out-of-range indices match no channel.
    logic we_ch;
    assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

    led_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD),
      .RST_MODE   (RST_MODE)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_i       (tick_q),
      .we_i         (we_ch),
      .cfg_mode_i   (cfg_mode),
      .cfg_period_i (cfg_period),
      .led_o        (led[i]),
      .busy_o       (busy[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl. Five channels so that a 3-bit cfg_ch
// can address an out-of-range index. Timeline is tracked in posedges since
// reset release (ecnt); tick is high across edges that are multiples of 10.
module tb_led_pattern_ctrl;
  import led_pattern_ctrl_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [NUM_CH-1:0] led, busy;
  logic              tick;

  int checks = 0;
  int errors = 0;
  int unsigned ecnt;

  led_pattern_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(10), .RST_PERIOD(499), .RST_MODE(2'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .led(led), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to 1 time unit after edge n (no-op if already there).
  task automatic goto_edge(input int unsigned n);
    while (ecnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe a write so it is captured on edge n.
  task automatic wr(input int ch, input logic [1:0] m, input int p, input int unsigned n);
    goto_edge(n - 1);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_mode = m; cfg_period = CNT_W'(p);
    goto_edge(n);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (led !== 5'b0 || busy !== 5'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL reset_outs: led=%b busy=%b tick=%b exp 0/0/0", led, busy, tick);
    end
    @(negedge clk); rst_n = 1'b1;
    goto_edge(8);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_e8: got %b exp 0", tick); end
    goto_edge(9);
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL tick_e9: got %b exp 1", tick); end
    goto_edge(10);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_e10: got %b exp 0", tick); end
    goto_edge(4999);
    checks++; if (led !== 5'b00000) begin errors++; $display("FAIL led_e4999: got %b exp 00000", led); end
    goto_edge(5000);
    checks++; if (led !== 5'b11111) begin errors++; $display("FAIL led_e5000: got %b exp 11111", led); end
    goto_edge(9999);
    checks++; if (led !== 5'b11111) begin errors++; $display("FAIL led_e9999: got %b exp 11111", led); end
    goto_edge(10000);
    checks++; if (led !== 5'b00000) begin errors++; $display("FAIL led_e10000: got %b exp 00000", led); end
  endtask

  task automatic test_blink_fast();
    wr(1, MODE_BLINK, 0, 10001);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL blink0_wr: got %b exp 00010", led); end
    goto_edge(10009);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL blink0_hold: got %b exp 00010", led); end
    goto_edge(10010);
    checks++; if (led !== 5'b00000) begin errors++; $display("FAIL blink0_t1: got %b exp 00000", led); end
    goto_edge(10020);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL blink0_t2: got %b exp 00010", led); end
  endtask

  task automatic test_oneshot();
    wr(2, MODE_ONESHOT, 3, 10021);
    checks++; if (led[2] !== 1'b1 || busy !== 5'b00100) begin
      errors++; $display("FAIL os_start: led2=%b busy=%b exp 1/00100", led[2], busy);
    end
    goto_edge(10059);
    checks++; if (led[2] !== 1'b1 || busy !== 5'b00100) begin
      errors++; $display("FAIL os_last: led2=%b busy=%b exp 1/00100", led[2], busy);
    end
    goto_edge(10060);
    checks++; if (led[2] !== 1'b0 || busy !== 5'b00000) begin
      errors++; $display("FAIL os_end: led2=%b busy=%b exp 0/00000", led[2], busy);
    end
    goto_edge(10070);
    checks++; if (led[2] !== 1'b0 || busy !== 5'b00000) begin
      errors++; $display("FAIL os_stays_off: led2=%b busy=%b exp 0/00000", led[2], busy);
    end
    wr(2, MODE_ONESHOT, 3, 10071);
    checks++; if (busy !== 5'b00100) begin errors++; $display("FAIL os2_start: busy=%b exp 00100", busy); end
    wr(2, MODE_ONESHOT, 3, 10090);   // re-write on tick 2
    goto_edge(10110);                // original pulse would have ended here
    checks++; if (busy !== 5'b00100) begin errors++; $display("FAIL os_rewr_ext: busy=%b exp 00100", busy); end
    goto_edge(10129);
    checks++; if (busy !== 5'b00100) begin errors++; $display("FAIL os_rewr_last: busy=%b exp 00100", busy); end
    goto_edge(10130);
    checks++; if (busy !== 5'b00000 || led[2] !== 1'b0) begin
      errors++; $display("FAIL os_rewr_end: busy=%b led2=%b exp 00000/0", busy, led[2]);
    end
  endtask

  task automatic test_write_on_tick();
    goto_edge(10139);
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL wt_tick: got %b exp 1", tick); end
    wr(0, MODE_BLINK, 5, 10140);
    checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL wt_led: got %b exp 1", led[0]); end
    goto_edge(10199);
    checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL wt_hold: got %b exp 1", led[0]); end
    goto_edge(10200);
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL wt_toggle: got %b exp 0", led[0]); end
  endtask

  task automatic test_out_of_range();
    wr(5, MODE_ON, 0, 10201);
    checks++; if (led !== 5'b00010 || busy !== 5'b0) begin
      errors++; $display("FAIL oor_on: led=%b busy=%b exp 00010/00000", led, busy);
    end
    wr(7, MODE_ONESHOT, 2, 10203);
    checks++; if (led !== 5'b00010 || busy !== 5'b0) begin
      errors++; $display("FAIL oor_os: led=%b busy=%b exp 00010/00000", led, busy);
    end
    goto_edge(10215);
    checks++; if (led !== 5'b00000) begin errors++; $display("FAIL oor_later: led=%b exp 00000", led); end
    wr(3, MODE_ON, 0, 10221);
    checks++; if (led !== 5'b01010) begin errors++; $display("FAIL ch3_on: led=%b exp 01010", led); end
    goto_edge(10230);
    checks++; if (led !== 5'b01000) begin errors++; $display("FAIL ch3_on_tick: led=%b exp 01000", led); end
    wr(3, MODE_OFF, 0, 10231);
    checks++; if (led !== 5'b00000) begin errors++; $display("FAIL ch3_off: led=%b exp 00000", led); end
  endtask

  task automatic test_async_reset();
    wr(2, MODE_ONESHOT, 9, 10241);
    goto_edge(10249);
    checks++; if (led !== 5'b00110 || busy !== 5'b00100 || tick !== 1'b1) begin
      errors++; $display("FAIL pre_rst: led=%b busy=%b tick=%b exp 00110/00100/1", led, busy, tick);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led !== 5'b0 || busy !== 5'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL async_rst: led=%b busy=%b tick=%b exp 0/0/0", led, busy, tick);
    end
    test_reset();
  endtask

  initial begin
    test_reset();
    test_blink_fast();
    test_oneshot();
    test_write_on_tick();
    test_out_of_range();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
